// File: rtl/regfile8_onehot_pkg.sv
// Shared definitions for the 8-entry register file and its scoreboard.
// Holds sizing constants and the one-hot legality check used on write vectors.
package regfile8_onehot_pkg;

    localparam int REG_COUNT  = 8;
    localparam int REG_IDX_W  = 3;
    localparam int DEF_DATA_W = 16;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    function automatic logic isOneHot8(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy (pending-write) bits for decode-stage stall logic.
// Ports: clk, reset (sync, active-high), issueValid/issueDest mark a new
// producer, wrVec is the already-legalised write vector, busyMask is the state.
module regfile_scoreboard
    import regfile8_onehot_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issueValid,
    input  logic [REG_IDX_W-1:0] issueDest,
    input  logic [REG_COUNT-1:0] wrVec,
    output logic [REG_COUNT-1:0] busyMask
);

    logic [REG_COUNT-1:0] r_busy;
    logic [REG_COUNT-1:0] w_set;

    always_comb begin
        w_set = '0;
        if (issueValid) begin
            w_set[issueDest] = 1'b1;
        end
    end

    // A new producer supersedes the one completing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_set | (r_busy & ~wrVec);
        end
    end

    assign busyMask = r_busy;

endmodule

// File: rtl/regfile8_onehot.sv
// 8-entry register file with write bypass, busy scoreboard and multi-hot check.
// Ports: clk, reset (sync, active-high); wrOneHot/wrData write port;
// rdAddrA/B -> rdDataA/B, busyA/B (combinational); issueValid/issueDest
// feed the scoreboard; busyMask and sticky multiHotErr are registered.
module regfile8_onehot
    import regfile8_onehot_pkg::*;
#(
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_COUNT-1:0] wrOneHot,
    input  logic [DATA_W-1:0]    wrData,
    input  logic [REG_IDX_W-1:0] rdAddrA,
    input  logic [REG_IDX_W-1:0] rdAddrB,
    output logic [DATA_W-1:0]    rdDataA,
    output logic [DATA_W-1:0]    rdDataB,
    input  logic                 issueValid,
    input  logic [REG_IDX_W-1:0] issueDest,
    output logic                 busyA,
    output logic                 busyB,
    output logic [REG_COUNT-1:0] busyMask,
    output logic                 multiHotErr
);

    logic [DATA_W-1:0]    r_regs [REG_COUNT];
    logic                 r_err;
    logic                 w_legal;
    logic                 w_multi;
    logic [REG_COUNT-1:0] w_wrVec;

    // Illegal vectors are masked to zero so nothing downstream sees them.
    assign w_legal = isOneHot8(wrOneHot);
    assign w_multi = (wrOneHot != '0) && !w_legal;
    assign w_wrVec = w_legal ? wrOneHot : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= RESET_VAL;
            end
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_wrVec[i]) begin
                    r_regs[i] <= wrData;
                end
            end
            if (w_multi) begin
                r_err <= 1'b1;
            end
        end
    end

    regfile_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .issueValid (issueValid),
        .issueDest  (issueDest),
        .wrVec      (w_wrVec),
        .busyMask   (busyMask)
    );

    // A completing write is forwarded and un-stalls its reader this cycle.
    assign rdDataA = w_wrVec[rdAddrA] ? wrData : r_regs[rdAddrA];
    assign rdDataB = w_wrVec[rdAddrB] ? wrData : r_regs[rdAddrB];
    assign busyA   = busyMask[rdAddrA] & ~w_wrVec[rdAddrA];
    assign busyB   = busyMask[rdAddrB] & ~w_wrVec[rdAddrB];

    assign multiHotErr = r_err;

endmodule
